enemy_hp_tracker: RTL

//  Downstream stage of the player's good-bullet unit. Consumes the 1-cycle isHit pulse,

---
 rtl/enemy_hp_tracker_pkg.sv | 28 ++
 rtl/enemy_hp_tracker_frame_timer.sv | 43 ++++
 rtl/enemy_hp_tracker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/enemy_hp_tracker_pkg.sv
// Shared game package: enemy hp-FSM state encoding and the enemy tuning
// constants, kept next to the player/bullet geometry the bullet unit uses.
package enemy_hp_tracker_pkg;

    // Player / bullet geometry (consumed by the bullet unit)
    localparam int PLAYER_W     = 32;
    localparam int PLAYER_H     = 32;
    localparam int BULLET_W     = 4;
    localparam int BULLET_H     = 8;

    // Enemy hit-point tuning
    localparam int EHP_MAX_HP     = 10;
    localparam int EHP_DAMAGE     = 2;
    localparam int EHP_DEF_DAMAGE = 0;
    localparam int EHP_INVULN_CYC = 16;
    localparam int EHP_KO_CYC     = 64;
    localparam int EHP_FLASH_BIT  = 1;
    localparam int EHP_BAR_UNIT   = 20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIVE  = 3'd1,
        ST_INVULN = 3'd2,
        ST_KO     = 3'd3,
        ST_DONE   = 3'd4
    } hp_state_t;

endpackage

// File: rtl/enemy_hp_tracker_frame_timer.sv
// frame_timer: loadable down-counter with a zero flag. The counter stops at
// zero rather than wrapping. cnt_nxt exposes the value the counter will hold
// after the coming edge so the owner can register outputs derived from it.
// Ports:
//   clk, rst        clock, async active-high reset (counter clears to 0)
//   load, load_val  load load_val on the next edge (wins over dec)
//   dec             decrement by one on the next edge when not at zero
//   cnt, cnt_nxt    current and next counter value
//   zero            cnt == 0
module frame_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_nxt = cnt_q;
        if (load)
            cnt_nxt = load_val;
        else if (dec && (cnt_q != '0))
            cnt_nxt = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_nxt;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/enemy_hp_tracker.sv
// enemy_hp_tracker: applies bullet damage to the enemy's hit points and runs
// the invulnerability and KO timers. All outputs are registered.
// Ports:
//   clk, rst     game clock, async active-high reset
//   start        pulse: begin/restart the round (priority over hit)
//   hit          pulse: bullet hit the enemy
//   defend       enemy in defend stance (selects DEF_DAMAGE)
//   hp, hp_bar   hit points and hp*BAR_UNIT bar length
//   flash        sprite blink during invulnerability
//   hit_ack      pulse: damage > 0 applied
//   blocked      pulse: hit accepted with zero damage
//   ko, done     KO animation running or finished / round finished
//
// state     | meaning
// ST_IDLE   | before the first start; hits ignored
// ST_ALIVE  | hits accepted and damage applied
// ST_INVULN | post-hit invulnerability, timer running, sprite blinks
// ST_KO     | hp reached 0, KO animation timer running
// ST_DONE   | round over, waiting for start
module enemy_hp_tracker
    import enemy_hp_tracker_pkg::*;
#(
    parameter int MAX_HP     = EHP_MAX_HP,
    parameter int DAMAGE     = EHP_DAMAGE,
    parameter int DEF_DAMAGE = EHP_DEF_DAMAGE,
    parameter int INVULN_CYC = EHP_INVULN_CYC,
    parameter int KO_CYC     = EHP_KO_CYC,
    parameter int FLASH_BIT  = EHP_FLASH_BIT,
    parameter int BAR_UNIT   = EHP_BAR_UNIT,
    localparam int HPW       = $clog2(MAX_HP + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           hit,
    input  logic           defend,
    output logic [HPW-1:0] hp,
    output logic [10:0]    hp_bar,
    output logic           flash,
    output logic           hit_ack,
    output logic           blocked,
    output logic           ko,
    output logic           done
);

    // Damage larger than MAX_HP behaves identically to MAX_HP; clamping keeps
    // it representable in HPW bits.
    localparam int DMG_C  = (DAMAGE > MAX_HP) ? MAX_HP : DAMAGE;
    localparam int DEF_C  = (DEF_DAMAGE > MAX_HP) ? MAX_HP : DEF_DAMAGE;
    localparam int TMAX   = (INVULN_CYC > KO_CYC) ? INVULN_CYC : KO_CYC;
    localparam int CW0    = $clog2(TMAX);
    localparam int CW     = (CW0 > FLASH_BIT) ? CW0 : FLASH_BIT + 1;
    localparam logic [10:0] BAR_RST = 11'(MAX_HP * BAR_UNIT);

    hp_state_t      state_q, state_nxt;
    logic [HPW-1:0] hp_q, hp_nxt, dmg, hp_sub;
    logic [10:0]    hp_bar_q, hp_bar_nxt;
    logic           flash_q, flash_nxt;
    logic           ack_q, ack_nxt;
    logic           blk_q, blk_nxt;
    logic           ko_q, done_q;

    logic           tmr_load, tmr_dec, tmr_zero;
    logic [CW-1:0]  tmr_val, tmr_cnt, tmr_cnt_nxt;

    frame_timer #(.W(CW)) u_frame_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .cnt_nxt  (tmr_cnt_nxt),
        .zero     (tmr_zero)
    );

    assign dmg    = defend ? HPW'(DEF_C) : HPW'(DMG_C);
    assign hp_sub = (hp_q > dmg) ? hp_q - dmg : '0;

    always_comb begin
        state_nxt = state_q;
        hp_nxt    = hp_q;
        ack_nxt   = 1'b0;
        blk_nxt   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;

        if (start) begin
            state_nxt = ST_ALIVE;
            hp_nxt    = HPW'(MAX_HP);
            tmr_load  = 1'b1;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (hit) begin
                        if (dmg == '0) begin
                            blk_nxt = 1'b1;
                        end else if (hp_sub != '0) begin
                            state_nxt = ST_INVULN;
                            hp_nxt    = hp_sub;
                            ack_nxt   = 1'b1;
                            tmr_load  = 1'b1;
                            tmr_val   = CW'(INVULN_CYC - 1);
                        end else begin
                            state_nxt = ST_KO;
                            hp_nxt    = '0;
                            ack_nxt   = 1'b1;
                            tmr_load  = 1'b1;
                            tmr_val   = CW'(KO_CYC - 1);
                        end
                    end
                end
                ST_INVULN: begin
                    if (tmr_zero) state_nxt = ST_ALIVE;
                    else          tmr_dec   = 1'b1;
                end
                ST_KO: begin
                    if (tmr_zero) state_nxt = ST_DONE;
                    else          tmr_dec   = 1'b1;
                end
                ST_IDLE, ST_DONE: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign hp_bar_nxt = 11'(hp_nxt) * 11'(BAR_UNIT);
    assign flash_nxt  = (state_nxt == ST_INVULN) && tmr_cnt_nxt[FLASH_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hp_q     <= HPW'(MAX_HP);
            hp_bar_q <= BAR_RST;
            flash_q  <= 1'b0;
            ack_q    <= 1'b0;
            blk_q    <= 1'b0;
            ko_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            hp_q     <= hp_nxt;
            hp_bar_q <= hp_bar_nxt;
            flash_q  <= flash_nxt;
            ack_q    <= ack_nxt;
            blk_q    <= blk_nxt;
            ko_q     <= (state_nxt == ST_KO) || (state_nxt == ST_DONE);
            done_q   <= (state_nxt == ST_DONE);
        end
    end

    assign hp      = hp_q;
    assign hp_bar  = hp_bar_q;
    assign flash   = flash_q;
    assign hit_ack = ack_q;
    assign blocked = blk_q;
    assign ko      = ko_q;
    assign done    = done_q;

endmodule
